// File: rtl/pc_plus4_if.sv
// Bus bundle for the PC+4 sequential-address generator.
// The datapath owns PC; the generator returns the next address, its flags and their registered copies.
interface pc_plus4_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] Next_PC;
  logic            carry_out;
  logic            misaligned;
  logic [XLEN-1:0] Next_PC_q;
  logic            carry_q;
  logic            misaligned_q;
  logic            valid_q;

  modport master (
    output PC,
    input  Next_PC, carry_out, misaligned,
    input  Next_PC_q, carry_q, misaligned_q, valid_q
  );

  modport slave (
    input  PC,
    output Next_PC, carry_out, misaligned,
    output Next_PC_q, carry_q, misaligned_q, valid_q
  );
endinterface

// File: rtl/pc_plus4.sv
// Sequential-address generator: combinational PC + INC with wrap/misalignment flags,
// plus a one-cycle registered copy of all three and a valid flag.
module pc_plus4 #(
  parameter int          XLEN       = 32,
  parameter int unsigned INC        = 4,
  parameter int          ALIGN_BITS = 2
) (
  input logic        clk,
  input logic        rst,
  pc_plus4_if.slave  bus
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] nextPc_d, nextPc_q;
  logic            carry_d, carry_q;
  logic            misaligned_d, misaligned_q;
  logic            valid_q;

  // One extra sum bit exposes the address wrap as carry_out.
  assign sum           = {1'b0, bus.PC} + (XLEN+1)'(INC);
  assign bus.Next_PC   = sum[XLEN-1:0];
  assign bus.carry_out = sum[XLEN];

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign bus.misaligned = |bus.PC[ALIGN_BITS-1:0];
    end else begin : g_noAlign
      assign bus.misaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    nextPc_d     = bus.Next_PC;
    carry_d      = bus.carry_out;
    misaligned_d = bus.misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nextPc_q     <= '0;
      carry_q      <= 1'b0;
      misaligned_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      nextPc_q     <= nextPc_d;
      carry_q      <= carry_d;
      misaligned_q <= misaligned_d;
      valid_q      <= 1'b1;
    end
  end

  assign bus.Next_PC_q    = nextPc_q;
  assign bus.carry_q      = carry_q;
  assign bus.misaligned_q = misaligned_q;
  assign bus.valid_q      = valid_q;

endmodule

// File: tb/tb_pc_plus4.sv
// Directed self-checking bench for pc_plus4: a table of combinational vectors
// followed by hand-written reset and registered-tracking sequences.
module tb_pc_plus4;

  logic clk;
  logic rst;
  logic clkRun;
  int   checks;
  int   failures;

  pc_plus4_if #(.XLEN(32)) bus ();

  pc_plus4 #(.XLEN(32), .INC(4), .ALIGN_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] expNext;
    logic        expCarry;
    logic        expMis;
  } vec_t;

  vec_t vecs[11];

  initial clk = 1'b0;
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic rstVal);
    @(negedge clk);
    bus.PC = pc;
    rst    = rstVal;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clkRun   = 1'b0;
    rst      = 1'b0;
    bus.PC   = '0;

    vecs[0]  = '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0008, 32'h0000_000C, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_000C, 32'h0000_0010, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0010, 32'h0000_0014, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_0002, 32'h0000_0006, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_1001, 32'h0000_1005, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_1000, 32'h0000_1004, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1};

    // Clock held idle: the combinational path must not need it.
    for (int i = 0; i < 11; i++) begin
      bus.PC = vecs[i].pc;
      #100;
      checkOutput($sformatf("Next_PC[%0d]", i), bus.Next_PC, vecs[i].expNext);
      checkOutput($sformatf("carry_out[%0d]", i), {31'b0, bus.carry_out}, {31'b0, vecs[i].expCarry});
      checkOutput($sformatf("misaligned[%0d]", i), {31'b0, bus.misaligned}, {31'b0, vecs[i].expMis});
    end

    clkRun = 1'b1;

    // Reset held for two edges with PC = 0x40.
    applyStimulus(32'h0000_0040, 1'b1);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checkOutput("rst Next_PC_q", bus.Next_PC_q, 32'h0);
      checkOutput("rst valid_q", {31'b0, bus.valid_q}, 32'h0);
      checkOutput("rst carry_q", {31'b0, bus.carry_q}, 32'h0);
      checkOutput("rst misaligned_q", {31'b0, bus.misaligned_q}, 32'h0);
      checkOutput("rst Next_PC comb", bus.Next_PC, 32'h0000_0044);
    end
    applyStimulus(32'h0000_0040, 1'b0);
    @(posedge clk); #1;
    checkOutput("release Next_PC_q", bus.Next_PC_q, 32'h0000_0044);
    checkOutput("release valid_q", {31'b0, bus.valid_q}, 32'h1);

    // Registered tracking, one cycle behind PC.
    applyStimulus(32'h0000_0100, 1'b0);
    checkOutput("track hold Next_PC_q", bus.Next_PC_q, 32'h0000_0044);
    @(posedge clk); #1;
    checkOutput("track0 Next_PC_q", bus.Next_PC_q, 32'h0000_0104);
    checkOutput("track0 carry_q", {31'b0, bus.carry_q}, 32'h0);
    applyStimulus(32'hFFFF_FFFC, 1'b0);
    @(posedge clk); #1;
    checkOutput("track1 Next_PC_q", bus.Next_PC_q, 32'h0000_0000);
    checkOutput("track1 carry_q", {31'b0, bus.carry_q}, 32'h1);
    applyStimulus(32'h0000_0002, 1'b0);
    @(posedge clk); #1;
    checkOutput("track2 Next_PC_q", bus.Next_PC_q, 32'h0000_0006);
    checkOutput("track2 misaligned_q", {31'b0, bus.misaligned_q}, 32'h1);
    checkOutput("track2 carry_q", {31'b0, bus.carry_q}, 32'h0);

    // Reset asserted for a single edge mid-run.
    applyStimulus(32'h0000_0200, 1'b1);
    @(posedge clk); #1;
    checkOutput("midrst Next_PC_q", bus.Next_PC_q, 32'h0);
    checkOutput("midrst carry_q", {31'b0, bus.carry_q}, 32'h0);
    checkOutput("midrst misaligned_q", {31'b0, bus.misaligned_q}, 32'h0);
    checkOutput("midrst valid_q", {31'b0, bus.valid_q}, 32'h0);
    checkOutput("midrst Next_PC comb", bus.Next_PC, 32'h0000_0204);
    applyStimulus(32'h0000_0200, 1'b0);
    @(posedge clk); #1;
    checkOutput("postrst Next_PC_q", bus.Next_PC_q, 32'h0000_0204);
    checkOutput("postrst valid_q", {31'b0, bus.valid_q}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_plus4.md
Name: pc_plus4

Overview:
- Sequential-address generator for the RISC-V single-cycle datapath.
- Computes PC + 4 combinationally for the fetch stage's next-PC mux.
- Also provides a registered copy of the result and status flags (wrap, misalignment) for pipeline/debug use.
- The combinational path is independent of clock and reset, so the block works with `clk`/`rst` undriven.

Parameters:
- XLEN, 32, datapath width of PC and Next_PC in bits.
- INC, 4, byte increment added to PC; must be less than 2^XLEN.
- ALIGN_BITS, 2, number of low PC bits that must be zero for a valid instruction address.

Ports:
- clk  input  1  system clock; rising-edge active; used only by the registered outputs.
- rst  input  1  synchronous, active-high reset; affects only the registered outputs.
- PC  input  XLEN  current program counter.
- Next_PC  output  XLEN  PC + INC, combinational.
- carry_out  output  1  combinational; 1 when PC + INC overflows XLEN bits (address wrap).
- misaligned  output  1  combinational; 1 when PC[ALIGN_BITS-1:0] != 0.
- Next_PC_q  output  XLEN  registered Next_PC.
- carry_q  output  1  registered carry_out.
- misaligned_q  output  1  registered misaligned.
- valid_q  output  1  0 after reset; 1 from the first clock edge with rst low.

Behaviour:
- Next_PC = (PC + INC) mod 2^XLEN.
  - Purely combinational, zero latency; settles within the same delta/timestep as any PC change.
  - No dependence on clk or rst.
- carry_out = bit XLEN of the (XLEN+1)-bit sum {1'b0,PC} + INC. Example: PC = 32'hFFFF_FFFC gives Next_PC = 32'h0 and carry_out = 1.
- misaligned is computed on PC, not on Next_PC.
  - Next_PC is still computed normally when misaligned: PC = 32'h2 gives Next_PC = 32'h6.
  - The block does not flag or trap; it only reports.
- Unknown or X bits on PC propagate to the outputs per normal adder semantics; no masking.
- Registered path, on each rising clk edge:
  - If rst = 1: Next_PC_q = 0, carry_q = 0, misaligned_q = 0, valid_q = 0.
  - Else: Next_PC_q ← Next_PC, carry_q ← carry_out, misaligned_q ← misaligned, valid_q ← 1.
  - Latency PC → Next_PC_q is 1 cycle.
- Reset mid-operation: registered outputs clear on the next edge with rst = 1. Combinational outputs keep tracking PC throughout reset.
- Registered outputs hold their reset values until the first non-reset edge.
- Power-up values before the first edge are unspecified; verification must not check them.
- No handshake and no internal state other than the output registers.

Test Plan:
- Sequential sweep with clk idle: PC = 0x0, 0x4, 0x8, 0xC, 0x10, each held 100 ns → Next_PC = 0x4, 0x8, 0xC, 0x10, 0x14; carry_out = 0; misaligned = 0.
- Wrap: PC = 0xFFFF_FFFC → Next_PC = 0x0000_0000, carry_out = 1. PC = 0xFFFF_FFF8 → Next_PC = 0xFFFF_FFFC, carry_out = 0.
- Misalignment: PC = 0x2 → Next_PC = 0x6, misaligned = 1. PC = 0x1001 → Next_PC = 0x1005, misaligned = 1. PC = 0x1000 → misaligned = 0.
- Reset: rst = 1 for 2 edges with PC = 0x40 → Next_PC_q = 0, valid_q = 0, Next_PC = 0x44 throughout. Release rst → after 1 edge Next_PC_q = 0x44, valid_q = 1.
- Registered tracking: PC = 0x100 then 0xFFFF_FFFC on consecutive edges → Next_PC_q = 0x104 then 0x0, carry_q = 0 then 1, each one cycle after PC.
- Reset mid-run: assert rst for one edge while PC = 0x200 → Next_PC_q = 0, carry_q = 0, misaligned_q = 0, valid_q = 0 on that edge. Next edge gives Next_PC_q = 0x204.
